hilo_unit: RTL and testbench

HILO_UNIT -- requirements
Module: hilo_unit

---
 rtl/hilo_unit.sv | 212 +++++++++++++++++++++
 tb/tb_hilo_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register pair with iterative multiply and divide.
//
// Optional feature: define HILO_BYPASS_EN so that hi_o/lo_o show a pending
// HI/LO write combinationally in the cycle before it lands.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | accepts MTHI/MTLO/MULT/MULTU/DIV/DIVU; busy=0
// MUL   | shift-add multiply on operand magnitudes, one bit per cycle
// DIV   | restoring divide on operand magnitudes, one bit per cycle
//
// The signed ops run on magnitudes. The sign is fixed up on the final write.
module hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MTHI  = 3'd0;
  localparam logic [2:0] OP_MTLO  = 3'd1;
  localparam logic [2:0] OP_MULT  = 3'd2;
  localparam logic [2:0] OP_MULTU = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dz_q;

  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             last;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n;
  logic [WIDTH-1:0] mul_lo_n;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;

  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_n;
  logic [WIDTH-1:0] div_lo_n;

  logic             hi_wr;
  logic             lo_wr;
  logic [WIDTH-1:0] hi_wd;
  logic [WIDTH-1:0] lo_wd;

  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;

  // Decode the incoming request and take operand magnitudes.
  always_comb begin
    accept    = start && (state == IDLE) && !flush && !rst;
    is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = is_signed && src_a[WIDTH-1];
    b_neg     = is_signed && src_b[WIDTH-1];
    mag_a     = a_neg ? (~src_a + WIDTH'(1)) : src_a;
    mag_b     = b_neg ? (~src_b + WIDTH'(1)) : src_b;
    last      = (state != IDLE) && (cnt == '0) && !flush && !rst;
  end

  // One iteration of multiply and divide, plus the sign-corrected results.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
    prod     = {mul_hi_n, mul_lo_n};
    prod_s   = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;

    div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd};
    div_ge   = ~div_diff[WIDTH];
    div_hi_n = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_lo_n = {acc_lo[WIDTH-2:0], div_ge};
  end

  // HI/LO write enables and data for the coming edge.
  always_comb begin
    hi_wr = 1'b0;
    lo_wr = 1'b0;
    hi_wd = src_a;
    lo_wd = src_a;
    if (accept && (op == OP_MTHI)) begin
      hi_wr = 1'b1;
    end else if (accept && (op == OP_MTLO)) begin
      lo_wr = 1'b1;
    end else if (last && (state == MUL)) begin
      hi_wr = 1'b1;
      lo_wr = 1'b1;
      hi_wd = prod_s[2*WIDTH-1:WIDTH];
      lo_wd = prod_s[WIDTH-1:0];
    end else if (last && (state == DIV)) begin
      hi_wr = 1'b1;
      lo_wr = 1'b1;
      hi_wd = neg_r ? (~div_hi_n + WIDTH'(1)) : div_hi_n;
      lo_wd = neg_q ? (~div_lo_n + WIDTH'(1)) : div_lo_n;
    end
  end

`ifdef HILO_BYPASS_EN
  assign hi_o = hi_wr ? hi_wd : hi_q;
  assign lo_o = lo_wr ? lo_wd : lo_q;
`else
  assign hi_o = hi_q;
  assign lo_o = lo_q;
`endif

  // Sequencer, iteration datapath and HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      if (hi_wr) hi_q <= hi_wd;
      if (lo_wr) lo_q <= lo_wd;
      case (state)
        IDLE: begin
          if (accept && is_mul) begin
            state  <= MUL;
            cnt    <= CW'(WIDTH - 1);
            opnd   <= mag_a;
            acc_hi <= '0;
            acc_lo <= mag_b;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= 1'b0;
          end else if (accept && is_div) begin
            if (src_b == '0) begin
              // Divide by zero completes at once and leaves HI/LO alone.
              done_q <= 1'b1;
              dz_q   <= 1'b1;
            end else begin
              state  <= DIV;
              cnt    <= CW'(WIDTH - 1);
              opnd   <= mag_b;
              acc_hi <= '0;
              acc_lo <= mag_a;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
            end
          end
        end
        MUL, DIV: begin
          if (flush) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
            if (state == MUL) begin
              acc_hi <= mul_hi_n;
              acc_lo <= mul_lo_n;
            end else begin
              acc_hi <= div_hi_n;
              acc_lo <= div_lo_n;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed vectors for hilo_unit (WIDTH=32). Expected HI/LO/div_zero
// results are queued when an op is issued; a monitor pops them on each done pulse.
module tb_hilo_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         flush;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  hilo_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .div_zero(div_zero),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           id;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 expected no pending op");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check($sformatf("op%0d_hi", e.id), 64'(hi_o), 64'(e.hi));
          check($sformatf("op%0d_lo", e.id), 64'(lo_o), 64'(e.lo));
          check($sformatf("op%0d_dz", e.id), 64'(div_zero), 64'(e.dz));
          check($sformatf("op%0d_busy_at_done", e.id), 64'(busy), 64'd0);
        end
      end else begin
        check("dz_without_done", 64'(div_zero), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue an op, queue its expectation and count busy cycles up to the done cycle.
  task automatic run_op(input int id, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input logic edz, input int ebusy);
    exp_t e;
    int   cyc;
    e.hi = ehi; e.lo = elo; e.dz = edz; e.id = id;
    sb.push_back(e);
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
    end
    check($sformatf("op%0d_busy_cycles", id), 64'(cyc), 64'(ebusy));
    m_hi = ehi;
    m_lo = elo;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0; flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_lo", 64'(lo_o), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);

    // Back-to-back ops: each new start lands in the previous done cycle.
    run_op(1, 3'd2, 32'hFFFFFFFF, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 32);
    run_op(2, 3'd3, 32'hFFFFFFFF, 32'd2,          32'h00000001, 32'hFFFFFFFE, 1'b0, 32);
    run_op(3, 3'd4, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32);
    run_op(4, 3'd4, 32'h80000000, 32'hFFFFFFFF,   32'h00000000, 32'h80000000, 1'b0, 32);
    run_op(5, 3'd5, 32'd7,        32'd0,          32'h00000000, 32'h80000000, 1'b1, 0);
    run_op(6, 3'd5, 32'd100,      32'd7,          32'h00000002, 32'h0000000E, 1'b0, 32);
    run_op(7, 3'd4, 32'd7,        32'hFFFFFFFE,   32'h00000001, 32'hFFFFFFFD, 1'b0, 32);
    run_op(8, 3'd2, 32'hFFFFFFFD, 32'd5,          32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 32);
    run_op(9, 3'd3, 32'h80000000, 32'h80000000,   32'h40000000, 32'h00000000, 1'b0, 32);
    tick();
    check("drain_after_ops", 64'(sb.size()), 64'd0);

    // Reserved op codes leave everything alone.
    op = 3'd6; src_a = 32'h11111111; src_b = 32'd3; start = 1'b1;
    tick();
    op = 3'd7;
    tick();
    start = 1'b0;
    check("rsv_busy", 64'(busy), 64'd0);
    check("rsv_hi", 64'(hi_o), 64'(m_hi));
    check("rsv_lo", 64'(lo_o), 64'(m_lo));

    // MTHI: visible in the start cycle only with the bypass path.
    op = 3'd0; src_a = 32'h00001234; start = 1'b1;
    #1;
`ifdef HILO_BYPASS_EN
    check("mthi_same_cycle", 64'(hi_o), 64'h1234);
`else
    check("mthi_same_cycle", 64'(hi_o), 64'(m_hi));
`endif
    tick();
    start = 1'b0;
    m_hi = 32'h00001234;
    check("mthi_next_cycle", 64'(hi_o), 64'(m_hi));
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_lo_kept", 64'(lo_o), 64'(m_lo));

    op = 3'd1; src_a = 32'h00005678; start = 1'b1;
    tick();
    start = 1'b0;
    m_lo = 32'h00005678;
    check("mtlo", 64'(lo_o), 64'(m_lo));
    check("mtlo_hi_kept", 64'(hi_o), 64'(m_hi));

    // Start together with flush in IDLE is ignored.
    op = 3'd0; src_a = 32'h0000AAAA; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("idle_flush_start_hi", 64'(hi_o), 64'(m_hi));
    check("idle_flush_busy", 64'(busy), 64'd0);

    // MULTU 5x5 flushed at busy cycle 10; a start during busy is ignored.
    op = 3'd3; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check("flush_busy_c1", 64'(busy), 64'd1);
    for (int k = 1; k < 10; k++) begin
      if (k == 3) begin
        op = 3'd0; src_a = 32'h0000DEAD; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check("flush_busy_c10", 64'(busy), 64'd1);
    op = 3'd1; src_a = 32'h0000BEEF; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_busy_after", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    check("flush_hi", 64'(hi_o), 64'(m_hi));
    check("flush_lo", 64'(lo_o), 64'(m_lo));
    repeat (40) tick();
    check("flush_hi_late", 64'(hi_o), 64'(m_hi));
    check("flush_lo_late", 64'(lo_o), 64'(m_lo));

    // Reset in the middle of a divide abandons it.
    op = 3'd5; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("div_mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstdiv_hi", 64'(hi_o), 64'd0);
    check("rstdiv_lo", 64'(lo_o), 64'd0);
    check("rstdiv_busy", 64'(busy), 64'd0);
    check("rstdiv_done", 64'(done), 64'd0);
    repeat (40) tick();
    check("rstdiv_busy_late", 64'(busy), 64'd0);
    check("final_queue_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
